// File: rtl/hazard_controller.sv
// Hazard, flush, freeze and ECALL-halt sequencing for the 5-stage core.
// Hazard outputs are combinational from state and inputs; the halt flag and counters are registered.
module hazard_controller #(
    parameter int CNT_W      = 32,
    parameter int HALT_DRAIN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_ecall,
    input  logic             id_halt_req,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_write_enable,
    input  logic [4:0]       mem_rd,
    input  logic             mem_mem_read,
    input  logic             ex_redirect,
    input  logic             dcache_req,
    input  logic             dcache_hit,
    input  logic             dcache_resp_valid,
    output logic             is_stall,
    output logic             is_flush,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             pipe_freeze,
    output logic             is_halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    localparam int DW = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(HALT_DRAIN - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              ret_drain_q, ret_drain_d;
    logic              halted_q;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic load_use, ecall_haz, miss, haz_stall;
    logic run_eval, drain_eval;

    assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign ecall_haz = id_is_ecall && ((ex_write_enable && (ex_rd == 5'd17)) ||
                                       (mem_mem_read && (mem_rd == 5'd17)));
    assign miss      = dcache_req && !dcache_hit;

    // MEM_WAIT serves misses from both RUN and DRAIN; ret_drain_q picks where the resp cycle resumes.
    assign run_eval   = ((state_q == RUN) && !miss) ||
                        ((state_q == MEM_WAIT) && dcache_resp_valid && !ret_drain_q);
    assign drain_eval = ((state_q == DRAIN) && !miss) ||
                        ((state_q == MEM_WAIT) && dcache_resp_valid && ret_drain_q);

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        ret_drain_d = ret_drain_q;
        is_stall    = 1'b0;
        is_flush    = 1'b0;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_freeze = 1'b0;
        haz_stall   = 1'b0;

        unique case (state_q)
            RUN: if (miss) begin
                pipe_freeze = 1'b1;
                state_d     = MEM_WAIT;
                ret_drain_d = 1'b0;
            end
            MEM_WAIT: if (!dcache_resp_valid) pipe_freeze = 1'b1;
            DRAIN: if (miss) begin
                pipe_freeze = 1'b1;
                state_d     = MEM_WAIT;
                ret_drain_d = 1'b1;
            end
            HALTED: is_stall = 1'b1;
            default: ;
        endcase

        if (run_eval) begin
            state_d = RUN;
            if (ex_redirect) begin
                is_flush    = 1'b1;
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end else if (load_use || ecall_haz) begin
                is_stall  = 1'b1;
                haz_stall = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if (id_is_ecall && id_halt_req) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
        end

        if (drain_eval) begin
            is_stall = 1'b1;
            state_d  = DRAIN;
            if (drain_q == '0) state_d = HALTED;
            else               drain_d = drain_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            drain_q     <= '0;
            ret_drain_q <= 1'b0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            ret_drain_q <= ret_drain_d;
            halted_q    <= (state_d == HALTED);
            if (haz_stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (is_flush)  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign is_halted   = halted_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
endmodule
